alu_arbiter: RTL and testbench

Two-requester front end for the team's 12-bit ALU datapath. Arbitrates round-robin between two independent valid/ready command ports, registers the winning operands, runs one ALU operation, and returns the result with flags and a requester tag on a single valid/ready response port. It sits between the lab's command sources (e.g. a test-pattern generator and a register-file sequencer) and one shared ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 23 ++
 rtl/alu_arbiter_if.sv | 52 +++++
 rtl/alu_arbiter_core.sv | 57 +++++
 rtl/alu_arbiter.sv | 124 ++++++++++++
 tb/tb_alu_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared constants and types for the two-requester ALU arbiter and its datapath.
// The default widths live here so the interface, arbiter and core agree.
package alu_pkg;

    localparam int ALU_W     = 12;
    localparam int ALU_CNT_W = 16;

    localparam logic [2:0] OP_ABS = 3'd0;
    localparam logic [2:0] OP_SHL = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_NOT = 3'd5;
    localparam logic [2:0] OP_ADD = 3'd6;
    localparam logic [2:0] OP_SUB = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two command ports, the response port and the grant counters.
// Every port is valid/ready: a transfer happens on a rising clk edge where valid and ready are both high.
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CNT_W = ALU_CNT_W
);
    logic             req0_valid;
    logic             req0_ready;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic [2:0]       req0_op;

    logic             req1_valid;
    logic             req1_ready;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic [2:0]       req1_op;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [W-1:0]     rsp_z;
    logic             rsp_carry;
    logic             rsp_sign;
    logic             rsp_ov;

    logic [CNT_W-1:0] grant_cnt0;
    logic [CNT_W-1:0] grant_cnt1;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_z, rsp_carry, rsp_sign, rsp_ov,
        output rsp_ready,
        input  grant_cnt0, grant_cnt1
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_z, rsp_carry, rsp_sign, rsp_ov,
        input  rsp_ready,
        output grant_cnt0, grant_cnt1
    );

endinterface

// File: rtl/alu_arbiter_core.sv
// alu_core: purely combinational ALU producing result, carry, sign and overflow.
// Sign always follows the result MSB; carry/ov are zero except where an op defines them.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic [W-1:0] z,
    output logic         carry,
    output logic         sign,
    output logic         ov
);

    logic [W:0] sum;

    always_comb begin
        z     = '0;
        carry = 1'b0;
        ov    = 1'b0;
        sum   = '0;
        case (op)
            OP_ABS: begin
                // The most negative value has no positive twin and comes back unchanged.
                z  = a[W-1] ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
                ov = a[W-1] && (a[W-2:0] == '0);
            end
            OP_SHL: begin
                z     = {b[W-2:0], 1'b0};
                carry = b[W-1];
                ov    = b[W-1] ^ b[W-2];
            end
            OP_AND: z = a & b;
            OP_OR:  z = a | b;
            OP_XOR: z = a ^ b;
            OP_NOT: z = ~a;
            OP_ADD: begin
                sum   = {1'b0, a} + {1'b0, b};
                z     = sum[W-1:0];
                carry = sum[W];
                ov    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                // carry=1 means no borrow
                sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
                z     = sum[W-1:0];
                carry = sum[W];
                ov    = (a[W-1] != b[W-1]) && (sum[W-1] != a[W-1]);
            end
            default: z = '0;
        endcase
        sign = z[W-1];
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one alu_core: IDLE grants, EXEC computes, RESP holds the result.
// Define ALU_ARB_STATS_EN to build the per-requester grant counters; otherwise they read 0.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int W     = ALU_W,
    parameter int CNT_W = ALU_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output state_t        dbg_state
);

    state_t         state_q, state_d;
    logic           last_q;
    logic           winner;
    logic           rdy0, rdy1, hs;

    logic [W-1:0]   a_q, b_q;
    logic [2:0]     op_q;
    logic           id_q;

    logic [W-1:0]   core_z;
    logic           core_carry, core_sign, core_ov;

    logic [W-1:0]   rsp_z_q;
    logic           rsp_carry_q, rsp_sign_q, rsp_ov_q, rsp_id_q;

    alu_core #(.W(W)) u_core (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .z     (core_z),
        .carry (core_carry),
        .sign  (core_sign),
        .ov    (core_ov)
    );

    // On a tie the requester not granted last wins; readys never depend on rsp_ready.
    always_comb begin
        state_d = state_q;
        rdy0    = 1'b0;
        rdy1    = 1'b0;
        winner  = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
        case (state_q)
            IDLE: begin
                if (!rst) begin
                    rdy0 = bus.req0_valid && !winner;
                    rdy1 = bus.req1_valid && winner;
                end
                if (rdy0 || rdy1) state_d = EXEC;
            end
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign hs = rdy0 || rdy1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= 1'b0;
            rsp_z_q     <= '0;
            rsp_carry_q <= 1'b0;
            rsp_sign_q  <= 1'b0;
            rsp_ov_q    <= 1'b0;
            rsp_id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                a_q  <= winner ? bus.req1_a  : bus.req0_a;
                b_q  <= winner ? bus.req1_b  : bus.req0_b;
                op_q <= winner ? bus.req1_op : bus.req0_op;
                id_q <= winner;
            end
            if (state_q == EXEC) begin
                rsp_z_q     <= core_z;
                rsp_carry_q <= core_carry;
                rsp_sign_q  <= core_sign;
                rsp_ov_q    <= core_ov;
                rsp_id_q    <= id_q;
            end
            if (state_q == RESP && bus.rsp_ready) last_q <= rsp_id_q;
        end
    end

    assign bus.req0_ready = rdy0;
    assign bus.req1_ready = rdy1;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_z      = rsp_z_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_sign   = rsp_sign_q;
    assign bus.rsp_ov     = rsp_ov_q;
    assign dbg_state      = state_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (rdy0) cnt0_q <= cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (rdy1) cnt1_q <= cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.grant_cnt0 = cnt0_q;
    assign bus.grant_cnt1 = cnt1_q;
`else
    assign bus.grant_cnt0 = '0;
    assign bus.grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a randomized run against a
// transaction-level model of arbitration and ALU arithmetic.
`timescale 1ns/1ps
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int W     = ALU_W;
    localparam int CNT_W = ALU_CNT_W;
`ifdef ALU_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic   clk = 1'b0;
    logic   rst;
    state_t dbg_state;
    int     errors = 0;
    int     checks = 0;
    logic [15:0] exp_q[$];
    logic   model_last;

    always #5 clk = ~clk;

    alu_arbiter_if #(.W(W), .CNT_W(CNT_W)) bus ();

    alu_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Packed response: {id, ov, sign, carry, z}
    function automatic logic [15:0] ref_alu(input logic id, input logic [2:0] op,
                                            input logic [11:0] a, input logic [11:0] b);
        int sa, sb, ua, ub, r;
        logic [11:0] z;
        logic c, v;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'({20'd0, a});
        ub = int'({20'd0, b});
        c = 1'b0; v = 1'b0; z = '0; r = 0;
        case (op)
            3'd0: begin r = (sa < 0) ? -sa : sa; z = r[11:0]; v = (r > 2047); end
            3'd1: begin r = ub * 2; z = r[11:0]; c = (r > 4095); v = (sb * 2 > 2047) || (sb * 2 < -2048); end
            3'd2: z = a & b;
            3'd3: z = a | b;
            3'd4: z = a ^ b;
            3'd5: z = ~a;
            3'd6: begin r = ua + ub; z = r[11:0]; c = (r > 4095); v = (sa + sb > 2047) || (sa + sb < -2048); end
            default: begin r = ua - ub; z = r[11:0]; c = (ua >= ub); v = (sa - sb > 2047) || (sa - sb < -2048); end
        endcase
        return {id, v, z[11], c, z};
    endfunction

    function automatic logic [15:0] observed();
        return {bus.rsp_id, bus.rsp_ov, bus.rsp_sign, bus.rsp_carry, bus.rsp_z};
    endfunction

    task automatic set_req(input logic r, input logic v, input logic [2:0] op,
                           input logic [11:0] a, input logic [11:0] b);
        if (r) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one command from requester r while the arbiter is idle; lat counts
    // negedges from the accepting edge until rsp_valid (-1 if never accepted).
    task automatic send_one(input logic r, input logic [2:0] op, input logic [11:0] a,
                            input logic [11:0] b, output logic [15:0] obs, output int lat);
        int n;
        @(negedge clk);
        set_req(r, 1'b1, op, a, b);
        n = 0;
        #1;
        while (!(r ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            @(negedge clk); #1; n++;
        end
        obs = 'x;
        if (!(r ? bus.req1_ready : bus.req0_ready)) begin
            set_req(r, 1'b0, op, a, b);
            lat = -1;
            return;
        end
        @(posedge clk);
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            if (lat == 0) set_req(r, 1'b0, op, a, b);
            lat++;
            #1;
            if (bus.rsp_valid) break;
        end
        obs = observed();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.rsp_valid, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_handshake: got %b want 000", {bus.rsp_valid, bus.req0_ready, bus.req1_ready});
        end
        checks++;
        if (observed() !== 16'h0000) begin
            errors++; $display("FAIL reset_rsp: got %h want 0000", observed());
        end
        checks++;
        if ({bus.grant_cnt0, bus.grant_cnt1} !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus.grant_cnt0, bus.grant_cnt1);
        end
        checks++;
        if (dbg_state !== IDLE) begin
            errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [15:0] obs; int lat;
        send_one(1'b0, OP_ADD, 12'h7FF, 12'h001, obs, lat);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
        checks++;
        if (obs !== 16'h6800) begin errors++; $display("FAIL add_rsp: got %h want 6800", obs); end
    endtask

    task automatic test_sub();
        logic [15:0] obs; int lat;
        send_one(1'b1, OP_SUB, 12'h005, 12'h007, obs, lat);
        checks++;
        if (obs !== 16'hAFFE || lat !== 2) begin
            errors++; $display("FAIL sub_rsp: got %h lat %0d want AFFE lat 2", obs, lat);
        end
    endtask

    task automatic test_abs();
        logic [15:0] obs; int lat;
        send_one(1'b0, OP_ABS, 12'h800, 12'h123, obs, lat);
        checks++;
        if (obs !== 16'h6800) begin errors++; $display("FAIL abs_min: got %h want 6800", obs); end
        send_one(1'b0, OP_ABS, 12'hFFF, 12'h000, obs, lat);
        checks++;
        if (obs !== 16'h0001) begin errors++; $display("FAIL abs_m1: got %h want 0001", obs); end
    endtask

    task automatic test_contention();
        int cyc, n_rsp, acc;
        logic [3:0] gseq;
        logic [15:0] e;
        pulse_reset();
        model_last = 1'b1;
        exp_q.delete();
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b1, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        set_req(1'b1, 1'b1, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
        cyc = 0; n_rsp = 0; acc = -1; gseq = '0;
        while (n_rsp < 4 && cyc < 40) begin
            #1; cyc++;
            if (bus.rsp_valid) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                checks++;
                if (observed() !== e) begin errors++; $display("FAIL cont_rsp: got %h want %h", observed(), e); end
                model_last = e[15];
                n_rsp++;
            end
            if (bus.req0_ready || bus.req1_ready) begin
                checks++;
                if ({bus.req1_ready, bus.req0_ready} !== (model_last ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL cont_grant: got %b want %b", {bus.req1_ready, bus.req0_ready}, model_last ? 2'b01 : 2'b10);
                end
                acc = bus.req1_ready ? 1 : 0;
                if (exp_q.size() + n_rsp < 4) gseq[exp_q.size() + n_rsp] = bus.req1_ready;
                exp_q.push_back(acc == 1 ? ref_alu(1'b1, bus.req1_op, bus.req1_a, bus.req1_b)
                                         : ref_alu(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
            end
            @(negedge clk);
            if (acc >= 0)
                set_req(acc[0], 1'b1, 3'($urandom_range(0, 7)), 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            acc = -1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        checks++;
        if (n_rsp != 4 || gseq !== 4'b1010) begin
            errors++; $display("FAIL cont_order: got %0d rsps grants %b want 4 rsps grants 1010", n_rsp, gseq);
        end
        #1;
        checks++;
        if (bus.grant_cnt0 !== CNT_W'(STATS ? 2 : 0) || bus.grant_cnt1 !== CNT_W'(STATS ? 2 : 0)) begin
            errors++; $display("FAIL cont_cnt: got %0d/%0d want %0d/%0d", bus.grant_cnt0, bus.grant_cnt1, STATS ? 2 : 0, STATS ? 2 : 0);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] e, held;
        logic [2:0] op1;
        logic [11:0] a1, b1;
        op1 = 3'($urandom_range(0, 7)); a1 = 12'($urandom_range(0, 4095)); b1 = 12'($urandom_range(0, 4095));
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        set_req(1'b0, 1'b1, OP_XOR, 12'hA5A, 12'h3C3);
        e = ref_alu(1'b0, OP_XOR, 12'hA5A, 12'h3C3);
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_grant0: got %b want 01", {bus.req1_ready, bus.req0_ready});
        end
        @(negedge clk);
        bus.req0_valid = 1'b0;
        set_req(1'b1, 1'b1, op1, a1, b1);
        @(negedge clk); #1;
        held = observed();
        checks++;
        if (!bus.rsp_valid || held !== e) begin
            errors++; $display("FAIL bp_rsp: got valid %b %h want valid 1 %h", bus.rsp_valid, held, e);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (observed() !== held || !bus.rsp_valid || bus.req0_ready || bus.req1_ready) begin
                errors++; $display("FAIL bp_hold: got %h v%b r%b%b want %h v1 r00", observed(), bus.rsp_valid, bus.req1_ready, bus.req0_ready, held);
            end
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b010) begin
            errors++; $display("FAIL bp_next_grant: got %b want 010", {bus.rsp_valid, bus.req1_ready, bus.req0_ready});
        end
        @(negedge clk);
        bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (!bus.rsp_valid || observed() !== ref_alu(1'b1, op1, a1, b1)) begin
            errors++; $display("FAIL bp_rsp1: got v%b %h want v1 %h", bus.rsp_valid, observed(), ref_alu(1'b1, op1, a1, b1));
        end
    endtask

    task automatic test_reset_exec();
        bus.rsp_ready = 1'b1;
        pulse_reset();
        set_req(1'b0, 1'b1, OP_OR, 12'hA50, 12'h00A);
        set_req(1'b1, 1'b1, OP_AND, 12'hFFF, 12'h0F0);
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL rx_first_tie: got %b want 01", {bus.req1_ready, bus.req0_ready});
        end
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            errors++; $display("FAIL rx_second_tie: got %b want 10", {bus.req1_ready, bus.req0_ready});
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.req1_ready, bus.req0_ready} !== 3'b000) begin
            errors++; $display("FAIL rx_in_reset: got %b want 000", {bus.rsp_valid, bus.req1_ready, bus.req0_ready});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rx_no_rsp: got %b want 0", bus.rsp_valid); end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            errors++; $display("FAIL rx_tie_after_reset: got %b want 01", {bus.req1_ready, bus.req0_ready});
        end
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (!bus.rsp_valid || observed() !== ref_alu(1'b0, OP_OR, 12'hA50, 12'h00A)) begin
            errors++; $display("FAIL rx_resp: got v%b %h want v1 %h", bus.rsp_valid, observed(), ref_alu(1'b0, OP_OR, 12'hA50, 12'h00A));
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || observed() !== 16'h0000) begin
            errors++; $display("FAIL rx_resp_drop: got v%b %h want v0 0000", bus.rsp_valid, observed());
        end
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            checks++;
            if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rx_idle: got %b want 0", bus.rsp_valid); end
        end
    endtask

    task automatic test_random();
        logic busy, w;
        logic [1:0] exp_rdy;
        logic exp_valid;
        logic [15:0] e;
        int age;
        int cnt_exp [2];
        pulse_reset();
        model_last = 1'b1;
        exp_q.delete();
        busy = 1'b0; age = 0;
        cnt_exp[0] = 0; cnt_exp[1] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.req0_valid = 1'($urandom_range(0, 1));
            bus.req1_valid = 1'($urandom_range(0, 1));
            bus.req0_op = 3'($urandom_range(0, 7));
            bus.req1_op = 3'($urandom_range(0, 7));
            bus.req0_a = 12'($urandom_range(0, 4095)); bus.req0_b = 12'($urandom_range(0, 4095));
            bus.req1_a = 12'($urandom_range(0, 4095)); bus.req1_b = 12'($urandom_range(0, 4095));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (busy) age++;
            w = (bus.req0_valid && bus.req1_valid) ? ~model_last : bus.req1_valid;
            exp_rdy = (!busy && (bus.req0_valid || bus.req1_valid)) ? (w ? 2'b10 : 2'b01) : 2'b00;
            exp_valid = busy && (age >= 2);
            checks++;
            if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
                errors++; $display("FAIL rand_ready: cyc %0d got %b want %b", cyc, {bus.req1_ready, bus.req0_ready}, exp_rdy);
            end
            checks++;
            if (bus.rsp_valid !== exp_valid) begin
                errors++; $display("FAIL rand_valid: cyc %0d got %b want %b", cyc, bus.rsp_valid, exp_valid);
            end
            if (exp_valid) begin
                e = (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx;
                checks++;
                if (observed() !== e) begin
                    errors++; $display("FAIL rand_rsp: cyc %0d got %h want %h", cyc, observed(), e);
                end
                if (bus.rsp_ready) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    model_last = e[15];
                    busy = 1'b0;
                end
            end
            if (exp_rdy != 2'b00) begin
                exp_q.push_back(w ? ref_alu(1'b1, bus.req1_op, bus.req1_a, bus.req1_b)
                                  : ref_alu(1'b0, bus.req0_op, bus.req0_a, bus.req0_b));
                cnt_exp[w]++;
                busy = 1'b1;
                age = 0;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        checks++;
        if (bus.grant_cnt0 !== CNT_W'(STATS ? cnt_exp[0] : 0) || bus.grant_cnt1 !== CNT_W'(STATS ? cnt_exp[1] : 0)) begin
            errors++; $display("FAIL rand_cnt: got %0d/%0d want %0d/%0d", bus.grant_cnt0, bus.grant_cnt1,
                               STATS ? cnt_exp[0] : 0, STATS ? cnt_exp[1] : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req(1'b0, 1'b0, 3'd0, 12'd0, 12'd0);
        set_req(1'b1, 1'b0, 3'd0, 12'd0, 12'd0);
        test_reset();
        test_single();
        test_sub();
        test_abs();
        test_contention();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
